rv32i_issue_scheduler: RTL



---
 rtl/rv32i_issue_scheduler_pkg.sv | 75 +++++++
 rtl/rv32i_issue_scheduler_if.sv | 25 ++
 rtl/rv32i_issue_scheduler_scoreboard.sv | 56 +++++
 rtl/rv32i_issue_scheduler.sv | 108 ++++++++++
 4 files changed

// File: rtl/rv32i_issue_scheduler_pkg.sv
// Shared RV32I decode types and helpers for the issue scheduler.
package rv32i_issue_scheduler_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef struct packed {
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] imm;
        logic        decode_error;
    } rv32_fields_t;

    typedef struct packed {
        logic use_rs1;
        logic use_rs2;
        logic use_rd;
        logic serialize;
    } rv32i_operand_use_t;

    function automatic rv32_fields_t rv32_get_fields(input logic [31:0] inst);
        rv32_fields_t f;
        f.opcode       = inst[6:0];
        f.rd           = inst[11:7];
        f.funct3       = inst[14:12];
        f.rs1          = inst[19:15];
        f.rs2          = inst[24:20];
        f.funct7       = inst[31:25];
        f.imm          = '0;
        f.decode_error = 1'b0;
        case (inst[6:0])
            OPC_IMM, OPC_LOAD, OPC_JALR, OPC_SYSTEM:
                f.imm = {{20{inst[31]}}, inst[31:20]};
            OPC_STORE:
                f.imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            OPC_BRANCH:
                f.imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            OPC_LUI, OPC_AUIPC:
                f.imm = {inst[31:12], 12'b0};
            OPC_JAL:
                f.imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            OPC_OP:
                f.imm = '0;
            default:
                f.decode_error = 1'b1;
        endcase
        return f;
    endfunction

    function automatic rv32i_operand_use_t rv32i_get_operand_use(input logic [6:0] opcode);
        rv32i_operand_use_t u;
        u = '0;
        case (opcode)
            OPC_OP:                      begin u.use_rs1 = 1'b1; u.use_rs2 = 1'b1; u.use_rd = 1'b1; end
            OPC_IMM, OPC_LOAD, OPC_JALR: begin u.use_rs1 = 1'b1; u.use_rd = 1'b1; end
            OPC_STORE, OPC_BRANCH:       begin u.use_rs1 = 1'b1; u.use_rs2 = 1'b1; end
            OPC_LUI, OPC_AUIPC, OPC_JAL: u.use_rd = 1'b1;
            default:                     u.serialize = 1'b1;
        endcase
        return u;
    endfunction

endpackage

// File: rtl/rv32i_issue_scheduler_if.sv
// Fetch-in and issue-out streams of the scheduler; master = scheduler, slave = fetch/execute side.
// Both streams: a transfer happens on a rising clk edge where valid && ready; the sender holds valid and payload stable until then.
interface rv32i_issue_scheduler_if;
    import rv32i_issue_scheduler_pkg::*;

    logic         inst_valid;
    logic         inst_ready;
    logic [31:0]  inst_pc;
    logic [31:0]  inst_data;
    logic         issue_valid;
    logic         issue_ready;
    logic [31:0]  issue_pc;
    rv32_fields_t issue_fields;

    modport master (
        input  inst_valid, inst_pc, inst_data, issue_ready,
        output inst_ready, issue_valid, issue_pc, issue_fields
    );

    modport slave (
        output inst_valid, inst_pc, inst_data, issue_ready,
        input  inst_ready, issue_valid, issue_pc, issue_fields
    );

endinterface

// File: rtl/rv32i_issue_scheduler_scoreboard.sv
// 32-entry pending-write scoreboard; x0 never pends, set beats a same-cycle clear.
// RV32I_ISSUE_WB_BYPASS_EN: lookups ignore the register being retired this cycle.
module rv32i_issue_scheduler_scoreboard (
    input  logic        clk,
    input  logic        rst,
    input  logic        set_en,
    input  logic [4:0]  set_rd,
    input  logic        wb_valid,
    input  logic [4:0]  wb_rd,
    input  logic        flush_clr_en,
    input  logic [4:0]  flush_clr_rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [4:0]  rd,
    output logic        rs1_pend,
    output logic        rs2_pend,
    output logic        rd_pend,
    output logic        any_pend,
    output logic [31:0] pending
);

    logic [31:0] pending_q, pending_d;
    logic [31:0] wb_mask, flush_mask, visible;

    assign wb_mask    = wb_valid     ? (32'd1 << wb_rd)        : 32'd0;
    assign flush_mask = flush_clr_en ? (32'd1 << flush_clr_rd) : 32'd0;

`ifdef RV32I_ISSUE_WB_BYPASS_EN
    assign visible = pending_q & ~wb_mask;
`else
    assign visible = pending_q;
`endif

    assign rs1_pend = visible[rs1];
    assign rs2_pend = visible[rs2];
    assign rd_pend  = visible[rd];
    assign any_pend = |visible;
    assign pending  = pending_q;

    always_comb begin
        pending_d = pending_q & ~wb_mask & ~flush_mask;
        if (set_en) begin
            pending_d[set_rd] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

endmodule

// File: rtl/rv32i_issue_scheduler.sv
// In-order RV32I issue controller: decode, scoreboard hazard hold, registered issue stream.
// Optional RV32I_ISSUE_WB_BYPASS_EN lets a writeback release a waiting instruction in the same cycle.
module rv32i_issue_scheduler
    import rv32i_issue_scheduler_pkg::*;
#(
    parameter int SYSTEM_SERIALIZE  = 1,
    parameter int STALL_COUNT_WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    rv32i_issue_scheduler_if.master      bus,
    input  logic                         wb_valid,
    input  logic [4:0]                   wb_rd,
    input  logic                         flush,
    output logic [STALL_COUNT_WIDTH-1:0] stall_count,
    output logic [31:0]                  dbg_pending
);

    localparam bit SERIALIZE_EN = (SYSTEM_SERIALIZE != 0);

    rv32_fields_t       dec_fields;
    rv32i_operand_use_t dec_use;
    logic rs1_pend, rs2_pend, rd_pend, any_pend;
    logic hazard, inst_ready, capture, issue_fire, set_en, flush_clr_en;

    logic                         issue_valid_q, issue_valid_d;
    logic [31:0]                  issue_pc_q, issue_pc_d;
    rv32_fields_t                 issue_fields_q, issue_fields_d;
    logic                         issue_use_rd_q, issue_use_rd_d;
    logic [STALL_COUNT_WIDTH-1:0] stall_count_q, stall_count_d;

    always_comb begin
        dec_fields = rv32_get_fields(bus.inst_data);
        dec_use    = rv32i_get_operand_use(dec_fields.opcode);
        hazard     = (dec_use.use_rs1 && rs1_pend) ||
                     (dec_use.use_rs2 && rs2_pend) ||
                     (dec_use.use_rd  && rd_pend)  ||
                     (SERIALIZE_EN && dec_use.serialize && any_pend);
        inst_ready   = !rst && !hazard && (!issue_valid_q || bus.issue_ready) && !flush;
        capture      = bus.inst_valid && inst_ready;
        issue_fire   = issue_valid_q && bus.issue_ready;
        set_en       = capture && dec_use.use_rd;
        // A flushed instruction never reached execute, so its write will never retire.
        flush_clr_en = flush && issue_valid_q && !bus.issue_ready && issue_use_rd_q;
    end

    rv32i_issue_scheduler_scoreboard u_scoreboard (
        .clk          (clk),
        .rst          (rst),
        .set_en       (set_en),
        .set_rd       (dec_fields.rd),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .flush_clr_en (flush_clr_en),
        .flush_clr_rd (issue_fields_q.rd),
        .rs1          (dec_fields.rs1),
        .rs2          (dec_fields.rs2),
        .rd           (dec_fields.rd),
        .rs1_pend     (rs1_pend),
        .rs2_pend     (rs2_pend),
        .rd_pend      (rd_pend),
        .any_pend     (any_pend),
        .pending      (dbg_pending)
    );

    always_comb begin
        issue_valid_d  = issue_valid_q;
        issue_pc_d     = issue_pc_q;
        issue_fields_d = issue_fields_q;
        issue_use_rd_d = issue_use_rd_q;
        stall_count_d  = stall_count_q;
        if (issue_fire || flush) begin
            issue_valid_d = 1'b0;
        end
        if (capture) begin
            issue_valid_d  = 1'b1;
            issue_pc_d     = bus.inst_pc;
            issue_fields_d = dec_fields;
            issue_use_rd_d = dec_use.use_rd;
        end
        if (bus.inst_valid && hazard && !flush && (stall_count_q != '1)) begin
            stall_count_d = stall_count_q + STALL_COUNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            issue_valid_q  <= 1'b0;
            issue_pc_q     <= '0;
            issue_fields_q <= '0;
            issue_use_rd_q <= 1'b0;
            stall_count_q  <= '0;
        end else begin
            issue_valid_q  <= issue_valid_d;
            issue_pc_q     <= issue_pc_d;
            issue_fields_q <= issue_fields_d;
            issue_use_rd_q <= issue_use_rd_d;
            stall_count_q  <= stall_count_d;
        end
    end

    assign bus.inst_ready   = inst_ready;
    assign bus.issue_valid  = issue_valid_q;
    assign bus.issue_pc     = issue_pc_q;
    assign bus.issue_fields = issue_fields_q;
    assign stall_count      = stall_count_q;

endmodule
